// File: rtl/ar_stack_if.sv
// ---------------------------------------------------------------------------
// ar_stack_if
//   Bundles the W-bus side and the status side of the address register stack.
//   master : the datapath controller driving commands and load data.
//   slave  : the ar_stack block itself.
//
//   w      W bus load data
//   l_     active-low load of AR from w
//   p1     AR += P_STEP
//   m4_    active-low, AR -= M_STEP
//   push   save current AR on the LIFO
//   pop    restore AR from the LIFO top
//   ar     current AR value
//   carry  last increment wrapped past all-ones
//   borrow last decrement wrapped below zero
//   full   LIFO holds DEPTH entries
//   empty  LIFO holds no entries
//   err    sticky LIFO overflow/underflow
// ---------------------------------------------------------------------------
interface ar_stack_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] w;
  logic             l_;
  logic             p1;
  logic             m4_;
  logic             push;
  logic             pop;
  logic [WIDTH-1:0] ar;
  logic             carry;
  logic             borrow;
  logic             full;
  logic             empty;
  logic             err;

  modport master (
    output w, l_, p1, m4_, push, pop,
    input  ar, carry, borrow, full, empty, err
  );

  modport slave (
    input  w, l_, p1, m4_, push, pop,
    output ar, carry, borrow, full, empty, err
  );
endinterface

// File: rtl/ar_stack.sv
// ---------------------------------------------------------------------------
// ar_stack
//   CPU address register with W-bus load, +P_STEP / -M_STEP stepping,
//   wrap-around carry/borrow flags and a DEPTH-entry LIFO of saved AR values
//   for nested block transfers and interrupt save/restore.
//
//   clk_sys  system clock, all state changes on its rising edge
//   clr_     asynchronous active-low reset
//   bus      ar_stack_if slave modport (commands in, AR and status out)
// ---------------------------------------------------------------------------
module ar_stack #(
  parameter int WIDTH  = 16,
  parameter int P_STEP = 1,
  parameter int M_STEP = 4,
  parameter int DEPTH  = 4
) (
  input  logic        clk_sys,
  input  logic        clr_,
  ar_stack_if.slave   bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [WIDTH+1:0] P_EXT = (WIDTH+2)'(P_STEP);
  localparam logic [WIDTH+1:0] M_EXT = (WIDTH+2)'(M_STEP);

  logic [WIDTH-1:0] ar_q, ar_d;
  logic             carry_q, carry_d;
  logic             borrow_q, borrow_d;
  logic             err_q, err_d;
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];

  logic             full, empty;
  logic             valid_pop, exch, push_only;
  logic             wr_en;
  logic [AW-1:0]    top_idx, wr_idx;
  logic [WIDTH-1:0] top_val;
  logic [WIDTH+1:0] sum_ext;

  assign full  = (ptr_q == PW'(DEPTH));
  assign empty = (ptr_q == '0);

  assign valid_pop = bus.pop && !empty;
  // push together with a valid pop swaps AR with the top entry in place
  assign exch      = bus.push && valid_pop;
  // a push with an empty-pop still writes, since empty can never be full
  assign push_only = bus.push && !valid_pop && !full;
  assign wr_en     = exch || push_only;

  assign top_idx = AW'(ptr_q - PW'(1));
  assign wr_idx  = exch ? top_idx : ptr_q[AW-1:0];
  assign top_val = mem_q[top_idx];

  // Two guard bits: bit WIDTH+1 marks a negative true result (borrow),
  // bit WIDTH alone marks a result above all-ones (carry).
  assign sum_ext = {2'b00, ar_q}
                 + (bus.p1   ? P_EXT : '0)
                 - (!bus.m4_ ? M_EXT : '0);

  always_comb begin
    ar_d     = ar_q;
    carry_d  = carry_q;
    borrow_d = borrow_q;
    if (!bus.l_) begin
      ar_d     = bus.w;
      carry_d  = 1'b0;
      borrow_d = 1'b0;
    end else if (valid_pop) begin
      ar_d     = top_val;
      carry_d  = 1'b0;
      borrow_d = 1'b0;
    end else if (bus.p1 || !bus.m4_) begin
      ar_d     = sum_ext[WIDTH-1:0];
      carry_d  = sum_ext[WIDTH] && !sum_ext[WIDTH+1];
      borrow_d = sum_ext[WIDTH+1];
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (push_only)
      ptr_d = ptr_q + PW'(1);
    else if (valid_pop && !bus.push)
      ptr_d = ptr_q - PW'(1);
  end

  assign err_d = err_q
              || (bus.push && !valid_pop && full)
              || (bus.pop && empty);

  always_ff @(posedge clk_sys or negedge clr_) begin
    if (!clr_) begin
      ar_q     <= '0;
      carry_q  <= 1'b0;
      borrow_q <= 1'b0;
      err_q    <= 1'b0;
      ptr_q    <= '0;
    end else begin
      ar_q     <= ar_d;
      carry_q  <= carry_d;
      borrow_q <= borrow_d;
      err_q    <= err_d;
      ptr_q    <= ptr_d;
    end
  end

  // LIFO storage carries no reset; contents are meaningless until pushed.
  always_ff @(posedge clk_sys) begin
    if (wr_en)
      mem_q[wr_idx] <= ar_q;
  end

  assign bus.ar     = ar_q;
  assign bus.carry  = carry_q;
  assign bus.borrow = borrow_q;
  assign bus.full   = full;
  assign bus.empty  = empty;
  assign bus.err    = err_q;

endmodule

// File: tb/tb_ar_stack.sv
module tb_ar_stack;
  logic clk;
  logic clr_;
  int   errors = 0;
  int   checks = 0;

  ar_stack_if #(.WIDTH(16)) bus ();

  ar_stack #(
    .WIDTH(16), .P_STEP(1), .M_STEP(4), .DEPTH(4)
  ) dut (
    .clk_sys(clk),
    .clr_   (clr_),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
    $display("check %-14s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic idle();
    bus.w    = 16'h0000;
    bus.l_   = 1'b1;
    bus.p1   = 1'b0;
    bus.m4_  = 1'b1;
    bus.push = 1'b0;
    bus.pop  = 1'b0;
  endtask

  // One clock edge with the currently driven command, then back to idle.
  task automatic tick();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic load(input logic [15:0] v);
    bus.l_ = 1'b0;
    bus.w  = v;
    tick();
  endtask

  initial begin
    idle();
    clr_ = 1'b0;
    #12;
    chk("rst_ar",     32'(bus.ar),     32'h0);
    chk("rst_carry",  32'(bus.carry),  32'h0);
    chk("rst_borrow", 32'(bus.borrow), 32'h0);
    chk("rst_err",    32'(bus.err),    32'h0);
    chk("rst_empty",  32'(bus.empty),  32'h1);
    chk("rst_full",   32'(bus.full),   32'h0);
    clr_ = 1'b1;

    // load / step
    load(16'hbeef);
    chk("load_beef", 32'(bus.ar), 32'hbeef);
    bus.p1 = 1'b1; tick();
    chk("inc_bef0", 32'(bus.ar), 32'hbef0);
    bus.m4_ = 1'b0; tick();
    chk("dec_beec", 32'(bus.ar), 32'hbeec);
    chk("dec_carry",  32'(bus.carry),  32'h0);
    chk("dec_borrow", 32'(bus.borrow), 32'h0);

    // wrap
    load(16'hffff);
    bus.p1 = 1'b1; tick();
    chk("wrap_ar",    32'(bus.ar),    32'h0000);
    chk("wrap_carry", 32'(bus.carry), 32'h1);
    load(16'h0002);
    bus.m4_ = 1'b0; tick();
    chk("uwrap_ar",     32'(bus.ar),     32'hfffe);
    chk("uwrap_borrow", 32'(bus.borrow), 32'h1);
    chk("uwrap_carry",  32'(bus.carry),  32'h0);
    load(16'h1234);
    chk("ld_clr_c", 32'(bus.carry),  32'h0);
    chk("ld_clr_b", 32'(bus.borrow), 32'h0);

    // LIFO depth
    load(16'h1111); bus.push = 1'b1; tick();
    chk("push1_empty", 32'(bus.empty), 32'h0);
    load(16'h2222); bus.push = 1'b1; tick();
    load(16'h3333); bus.push = 1'b1; tick();
    chk("push3_full", 32'(bus.full), 32'h0);
    load(16'h4444); bus.push = 1'b1; tick();
    chk("push4_full", 32'(bus.full), 32'h1);
    chk("push4_err",  32'(bus.err),  32'h0);
    load(16'h5555); bus.push = 1'b1; tick();
    chk("ovf_err",  32'(bus.err),  32'h1);
    chk("ovf_full", 32'(bus.full), 32'h1);
    bus.pop = 1'b1; tick();
    chk("pop_4444", 32'(bus.ar), 32'h4444);
    chk("pop1_full", 32'(bus.full), 32'h0);
    bus.pop = 1'b1; tick();
    chk("pop_3333", 32'(bus.ar), 32'h3333);
    bus.pop = 1'b1; tick();
    chk("pop_2222", 32'(bus.ar), 32'h2222);
    bus.pop = 1'b1; tick();
    chk("pop_1111", 32'(bus.ar), 32'h1111);
    chk("pop_empty", 32'(bus.empty), 32'h1);

    // underflow after reset
    #2 clr_ = 1'b0;
    #2 clr_ = 1'b1;
    bus.pop = 1'b1; tick();
    chk("uf_ar",    32'(bus.ar),    32'h0000);
    chk("uf_err",   32'(bus.err),   32'h1);
    chk("uf_empty", 32'(bus.empty), 32'h1);
    bus.pop = 1'b1; bus.p1 = 1'b1; tick();
    chk("uf_p1_ar", 32'(bus.ar), 32'h0001);

    // simultaneous operations
    bus.l_ = 1'b0; bus.w = 16'h0100; bus.p1 = 1'b1; bus.m4_ = 1'b0; tick();
    chk("ld_prio", 32'(bus.ar), 32'h0100);
    bus.p1 = 1'b1; bus.m4_ = 1'b0; tick();
    chk("pm_00fd", 32'(bus.ar), 32'h00fd);
    chk("pm_borrow", 32'(bus.borrow), 32'h0);
    bus.push = 1'b1; bus.p1 = 1'b1; tick();
    chk("pushinc_ar", 32'(bus.ar),    32'h00fe);
    chk("pushinc_em", 32'(bus.empty), 32'h0);
    bus.push = 1'b1; bus.pop = 1'b1; tick();
    chk("xchg_ar",    32'(bus.ar),    32'h00fd);
    chk("xchg_empty", 32'(bus.empty), 32'h0);
    bus.pop = 1'b1; tick();
    chk("xchg_top", 32'(bus.ar),    32'h00fe);
    chk("xchg_emp", 32'(bus.empty), 32'h1);

    // combined step below zero: 2 + 1 - 4 = -1
    load(16'h0002);
    bus.p1 = 1'b1; bus.m4_ = 1'b0; tick();
    chk("pm_wrap_ar", 32'(bus.ar),     32'hffff);
    chk("pm_wrap_b",  32'(bus.borrow), 32'h1);
    chk("pm_wrap_c",  32'(bus.carry),  32'h0);

    // asynchronous reset between edges
    load(16'habcd); bus.push = 1'b1; tick();
    bus.push = 1'b1; tick();
    chk("pre_ar",  32'(bus.ar),    32'habcd);
    chk("pre_err", 32'(bus.err),   32'h1);
    @(negedge clk);
    clr_ = 1'b0;
    #1;
    chk("arst_ar",    32'(bus.ar),    32'h0);
    chk("arst_empty", 32'(bus.empty), 32'h1);
    chk("arst_err",   32'(bus.err),   32'h0);
    chk("arst_full",  32'(bus.full),  32'h0);
    #2 clr_ = 1'b1;
    tick();
    chk("post_ar", 32'(bus.ar), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
